cpu_ifetch: RTL and testbench



---
 rtl/cpu_ifetch.sv | 187 ++++++++++++++++++
 tb/tb_cpu_ifetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ifetch.sv
// Instruction fetch stage: one-entry word buffer in front of a req/gnt/rvalid memory bus.
// Define CPU_IFETCH_PREFETCH_EN to add a second entry filled by a next-address prefetch.
module cpu_ifetch #(
  parameter int unsigned width       = 16,
  parameter int unsigned iaddr_width = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [iaddr_width-1:0] iaddr,
  output logic [width-1:0]       idata,
  output logic                   stall,
  input  logic                   flush,
  output logic                   mem_req,
  output logic [iaddr_width-1:0] mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [width-1:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                 state, state_d;
  logic                   mem_req_d;
  logic [iaddr_width-1:0] mem_addr_d;
  logic                   kill, kill_d;
  logic [iaddr_width-1:0] a_addr, a_addr_d;
  logic [width-1:0]       a_data, a_data_d;
  logic                   a_valid, a_valid_d;
  logic                   a_hit, hit;
  logic                   resp_done, fill;

  assign a_hit     = a_valid && (a_addr == iaddr);
  assign stall     = ~hit;
  // response consumed on rvalid in RESP, or on a same-cycle gnt+rvalid in REQ
  assign resp_done = mem_rvalid && ((state == RESP) || ((state == REQ) && mem_gnt));
  assign fill      = resp_done && !kill && !flush;

`ifdef CPU_IFETCH_PREFETCH_EN
  logic [iaddr_width-1:0] b_addr, b_addr_d;
  logic [width-1:0]       b_data, b_data_d;
  logic                   b_valid, b_valid_d;
  logic                   pf_pending, pf_pending_d;
  logic                   pf_inflight, pf_inflight_d;
  logic                   b_hit;
  logic [iaddr_width-1:0] pf_addr;

  assign b_hit   = b_valid && (b_addr == iaddr);
  assign hit     = a_hit || b_hit;
  assign idata   = (b_hit && !a_hit) ? b_data : a_data;
  assign pf_addr = a_addr + iaddr_width'(1);
`else
  assign hit   = a_hit;
  assign idata = a_data;
`endif

  // next-state and datapath update
  always_comb begin
    state_d    = state;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    kill_d     = kill;
    a_addr_d   = a_addr;
    a_data_d   = a_data;
    a_valid_d  = a_valid;
`ifdef CPU_IFETCH_PREFETCH_EN
    b_addr_d      = b_addr;
    b_data_d      = b_data;
    b_valid_d     = b_valid;
    pf_pending_d  = pf_pending;
    pf_inflight_d = pf_inflight;
`endif

    case (state)
      IDLE: begin
        if (!hit && !flush) begin
          mem_req_d  = 1'b1;
          mem_addr_d = iaddr;
          state_d    = REQ;
        end
`ifdef CPU_IFETCH_PREFETCH_EN
        else if (a_hit && pf_pending && !flush) begin
          pf_pending_d = 1'b0;
          if (!(b_valid && (b_addr == pf_addr))) begin
            mem_req_d     = 1'b1;
            mem_addr_d    = pf_addr;
            pf_inflight_d = 1'b1;
            state_d       = REQ;
          end
        end
`endif
      end
      REQ: begin
        if (flush) kill_d = 1'b1;
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = mem_rvalid ? IDLE : RESP;
        end
      end
      RESP: begin
        if (flush) kill_d = 1'b1;
        if (mem_rvalid) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

`ifdef CPU_IFETCH_PREFETCH_EN
    // a demand miss elsewhere abandons the in-flight prefetch
    if ((state != IDLE) && pf_inflight && !hit && (iaddr != mem_addr)) kill_d = 1'b1;
    if (b_hit && !a_hit) begin
      a_addr_d     = b_addr;
      a_data_d     = b_data;
      a_valid_d    = 1'b1;
      b_valid_d    = 1'b0;
      pf_pending_d = 1'b1;
    end
`endif

    if (resp_done) kill_d = 1'b0;

`ifdef CPU_IFETCH_PREFETCH_EN
    if (resp_done) pf_inflight_d = 1'b0;
    if (fill && pf_inflight) begin
      b_addr_d  = mem_addr;
      b_data_d  = mem_rdata;
      b_valid_d = 1'b1;
    end else if (fill) begin
      a_addr_d     = mem_addr;
      a_data_d     = mem_rdata;
      a_valid_d    = 1'b1;
      pf_pending_d = 1'b1;
    end
`else
    if (fill) begin
      a_addr_d  = mem_addr;
      a_data_d  = mem_rdata;
      a_valid_d = 1'b1;
    end
`endif

    if (flush) begin
      a_valid_d = 1'b0;
`ifdef CPU_IFETCH_PREFETCH_EN
      b_valid_d    = 1'b0;
      pf_pending_d = 1'b0;
`endif
    end
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      kill     <= 1'b0;
      a_addr   <= '0;
      a_data   <= '0;
      a_valid  <= 1'b0;
`ifdef CPU_IFETCH_PREFETCH_EN
      b_addr      <= '0;
      b_data      <= '0;
      b_valid     <= 1'b0;
      pf_pending  <= 1'b0;
      pf_inflight <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
      kill     <= kill_d;
      a_addr   <= a_addr_d;
      a_data   <= a_data_d;
      a_valid  <= a_valid_d;
`ifdef CPU_IFETCH_PREFETCH_EN
      b_addr      <= b_addr_d;
      b_data      <= b_data_d;
      b_valid     <= b_valid_d;
      pf_pending  <= pf_pending_d;
      pf_inflight <= pf_inflight_d;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_ifetch.sv
// Bench for cpu_ifetch (default build): directed memory handshakes, with request and
// fill scoreboards checked by a negedge monitor.
module tb_cpu_ifetch;
  localparam int unsigned W  = 16;
  localparam int unsigned AW = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } fill_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] iaddr = '0;
  logic [W-1:0]  idata;
  logic          stall;
  logic          flush = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [W-1:0]  mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  int req_count = 0;
  int rc;
  logic [AW-1:0] exp_req_q[$];
  fill_t         exp_fill_q[$];
  logic          prev_req = 1'b0;
  logic          prev_stall = 1'b1;
  logic [AW-1:0] held_addr = '0;
  bit            bad_seen = 1'b0;

  always #5 clk = ~clk;

  cpu_ifetch #(.width(W), .iaddr_width(AW)) dut (
    .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata), .stall(stall), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: new requests and stall falling edges are matched against the scoreboards
  always @(negedge clk) begin : mon
    logic [AW-1:0] ea;
    fill_t         ef;
    if (mem_req && !prev_req) begin
      req_count++;
      if (exp_req_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL req_unexpected: got addr 0x%0h expected no request at %0t", mem_addr, $time);
      end else begin
        ea = exp_req_q.pop_front();
        check("req_addr", 32'(mem_addr), 32'(ea));
      end
      held_addr = mem_addr;
    end else if (mem_req && prev_req) begin
      check("req_addr_hold", 32'(mem_addr), 32'(held_addr));
    end
    if (!stall && prev_stall) begin
      if (exp_fill_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL data_unexpected: got idata 0x%0h expected stall at %0t", idata, $time);
      end else begin
        ef = exp_fill_q.pop_front();
        check("data_iaddr", 32'(iaddr), 32'(ef.addr));
        check("data_idata", 32'(idata), 32'(ef.data));
      end
    end
    if (!stall && (idata == 16'h7777)) bad_seen = 1'b1;
    prev_req   = mem_req;
    prev_stall = stall;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_idata", 32'(idata), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);

    // zero-latency memory: gnt and rvalid together
    iaddr = 10'h005;
    exp_req_q.push_back(10'h005);
    exp_fill_q.push_back({10'h005, 16'h1234});
    tick(); reset = 1'b0;
    tick();
    @(negedge clk); check("t1_req_latency", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    check("t1_stall", 32'(stall), 32'd0);
    check("t1_idata", 32'(idata), 32'h1234);

    // delayed gnt, rvalid two cycles later
    tick(); iaddr = 10'h010;
    exp_req_q.push_back(10'h010);
    exp_fill_q.push_back({10'h010, 16'hA5A5});
    tick();
    repeat (3) tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    @(negedge clk);
    check("t2_resp_req_low", 32'(mem_req), 32'd0);
    check("t2_resp_stall", 32'(stall), 32'd1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 16'hA5A5;
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("t2_stall", 32'(stall), 32'd0);
    check("t2_idata", 32'(idata), 32'hA5A5);

    // flush during RESP discards 0x7777, then refetch
    tick(); iaddr = 10'h020;
    exp_req_q.push_back(10'h020);
    exp_req_q.push_back(10'h020);
    exp_fill_q.push_back({10'h020, 16'h2222});
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk); check("t3_killed_stall", 32'(stall), 32'd1);
    tick();
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk); check("t3_idata", 32'(idata), 32'h2222);

    // flush while hitting invalidates the buffer
    tick(); flush = 1'b1;
    exp_req_q.push_back(10'h020);
    exp_fill_q.push_back({10'h020, 16'h2AAA});
    tick();
    flush = 1'b0;
    @(negedge clk); check("t4_flush_hit_stall", 32'(stall), 32'd1);
    tick();
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h2AAA;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk); check("t4_idata", 32'(idata), 32'h2AAA);

    // flush in REQ before gnt: handshake completes, data dropped
    tick(); iaddr = 10'h030;
    exp_req_q.push_back(10'h030);
    exp_req_q.push_back(10'h030);
    exp_fill_q.push_back({10'h030, 16'h3030});
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk); check("t5_killed_stall", 32'(stall), 32'd1);
    tick();
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h3030;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk); check("t5_idata", 32'(idata), 32'h3030);

    // top address held: no refetch
    tick(); iaddr = 10'h3FF;
    exp_req_q.push_back(10'h3FF);
    exp_fill_q.push_back({10'h3FF, 16'h5A5A});
    tick();
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    rc = req_count;
    repeat (6) tick();
    @(negedge clk);
    check("t6_hold_stall", 32'(stall), 32'd0);
    check("t6_no_refetch", 32'(req_count), 32'(rc));

    // reset mid-RESP, late rvalid ignored, fresh request
    iaddr = 10'h040;
    exp_req_q.push_back(10'h040);
    exp_req_q.push_back(10'h040);
    exp_fill_q.push_back({10'h040, 16'h4040});
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("t7_rst_stall", 32'(stall), 32'd1);
    check("t7_rst_req", 32'(mem_req), 32'd0);
    check("t7_rst_idata", 32'(idata), 32'd0);
    tick(); reset = 1'b0;
    tick();
    tick();
    mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("t7_late_rvalid_stall", 32'(stall), 32'd1);
    check("t7_req_pending", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h4040;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk); check("t7_idata", 32'(idata), 32'h4040);

    repeat (3) tick();
    @(negedge clk);
    check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    check("fill_queue_drained", 32'(exp_fill_q.size()), 32'd0);
    check("killed_data_seen", 32'(bad_seen), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
